// File: rtl/multicycle_controller.sv
// Moore control FSM sequencing the multicycle RV32I datapath: per-state
// mux selects, enables, immediate format and ALU operation.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       Retire,
  output logic [3:0] State
);

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_FETCH    = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE   = 4'd1;
  localparam logic [STATE_W-1:0] S_MEMADR   = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMREAD  = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMWB    = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWRITE = 4'd5;
  localparam logic [STATE_W-1:0] S_EXECR    = 4'd6;
  localparam logic [STATE_W-1:0] S_EXECI    = 4'd7;
  localparam logic [STATE_W-1:0] S_ALUWB    = 4'd8;
  localparam logic [STATE_W-1:0] S_BRANCH   = 4'd9;
  localparam logic [STATE_W-1:0] S_JAL      = 4'd10;
  localparam logic [STATE_W-1:0] S_JALRADR  = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Internal ALU operation class, resolved to ALUControl below
  localparam logic [1:0] ALUOP_ADD  = 2'd0;
  localparam logic [1:0] ALUOP_SUB  = 2'd1;
  localparam logic [1:0] ALUOP_FUNC = 2'd2;

  logic [STATE_W-1:0] state_q, state_d;
  logic [1:0]         alu_op;
  logic               pc_update;
  logic               branch_taken;

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; unused codes fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALRADR;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALRADR:  state_d = S_JAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state outputs; enables are suppressed while reset is asserted
  always_comb begin
    pc_update    = 1'b0;
    branch_taken = 1'b0;
    alu_op       = ALUOP_ADD;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    RegWrite     = 1'b0;
    Retire       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        Retire    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        Retire   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNC;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNC;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA      = 2'b10;
        alu_op       = ALUOP_SUB;
        Retire       = 1'b1;
        branch_taken = Zero ^ funct3[0];
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_JALRADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      default: ;
    endcase
    PCWrite = pc_update | branch_taken;
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Retire   = 1'b0;
    end
  end

  // Immediate format decoded from op regardless of state
  always_comb begin
    ImmSrc = 2'b00;
    unique case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  // ALU operation: fixed add/sub or decoded from funct fields
  always_comb begin
    ALUControl = 3'b000;
    unique case (alu_op)
      ALUOP_SUB:  ALUControl = 3'b001;
      ALUOP_FUNC: begin
        unique case (funct3)
          3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default:    ALUControl = 3'b000;
    endcase
  end

  assign State = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore control FSM that sequences the multicycle RV32I datapath: shared instruction/data memory, IR/OldPC/A/WriteData/Data/ALUOut registers, one ALU reused for PC+4, branch target and data ops.
- Decodes op/funct fields and emits per-cycle mux selects, write enables, ImmSrc and ALUControl.
- Supported instructions: lw, sw, R-type, I-type ALU, beq/bne, jal, jalr.

Parameters:
- None. All encodings are fixed and listed below.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; state <= FETCH
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemWrite  out  1  memory write enable
- IRWrite  out  1  IR and OldPC enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=A
- ALUSrcB  out  2  00=WriteData, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  out  1  register file write enable
- Retire  out  1  high in the final cycle of each instruction
- State  out  4  current state code, for debug and verification

Behaviour:
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALRADR 11. Codes 12-15 go to FETCH on the next edge.
- Reset: takes effect at a clock edge, including mid-instruction; next state is FETCH.
  - While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and Retire are forced to 0.
  - All other outputs follow the current state.
- Outputs are a pure function of the current state plus op/funct/Zero. Unlisted enables are 0; unlisted selects are 00.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCUpdate=1 -> DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut <= OldPC+imm). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALRADR
  - any other op -> FETCH (executes as NOP, no Retire)
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. op[5]=0 -> MEMREAD; op[5]=1 -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, Retire=1 -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=func -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=func -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1 -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Retire=1 -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1 -> ALUWB (rd <= OldPC+4).
- JALRADR: ALUSrcA=10, ALUSrcB=01, add (ALUOut <= rs1+imm) -> JAL.
- PCWrite = PCUpdate | (state==BRANCH & (Zero ^ funct3[0])). funct3=000 is beq, 001 is bne.
- ImmSrc, decoded from op in every state:
  - I for lw, I-type ALU and jalr
  - S for sw
  - B for branch
  - J for jal
  - 00 for any other op
- ALUControl:
  - ALUOp=add -> 000; ALUOp=sub -> 001.
  - ALUOp=func, by funct3: 000 -> sub only when funct7b5 & op[5], else add; 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
- Instruction latencies in cycles: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5.

Test Plan:
- reset high for 2 cycles, released mid-MEMREAD -> State=0; PCWrite, IRWrite, MemWrite, RegWrite all 0 while reset=1; FETCH drives IRWrite=1, PCWrite=1, ALUSrcB=10.
- lw (op=0000011) -> State sequence 0,1,2,3,4,0; RegWrite=1, ResultSrc=01 and Retire=1 only in state 4; AdrSrc=1 in state 3.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECR; the same instruction with op=0010011 gives 000. funct3=110 gives 011.
- beq with Zero=1 -> PCWrite=1 in BRANCH. bne (funct3=001) with Zero=1 -> PCWrite=0. Both return to FETCH after 3 cycles.
- jalr (op=1100111) -> State sequence 0,1,11,10,8,0; ImmSrc=00; ALUSrcA=10 in state 11; PCWrite=1 in state 10; RegWrite=1 in state 8.
- Illegal op 1111111 -> DECODE -> FETCH; no RegWrite, MemWrite or Retire.
- State forced to 14 -> next State=0.
